simt_seq_ctrl: RTL and testbench

// - Scalar sequencer for a parametrised SIMT vector core: owns fetch PC, per-lane forward-branch
//   (divergence) PCs, min-reduction reconvergence skip, and a nested hardware-loop stack.
// - Sits between instruction memory and decode; execute reports BLTZ outcomes back here.
// - Adds over the previous core: LANES/PC_W generic, LOOP_DEPTH-deep SETX/LOOP nesting, stall, error flags.

---
 rtl/simt_seq_ctrl_pkg.sv | 23 ++
 rtl/simt_seq_ctrl_min_reduce.sv | 38 +++
 rtl/simt_seq_ctrl.sv | 138 +++++++++++++
 tb/tb_simt_seq_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/simt_seq_ctrl_pkg.sv
// Shared constants and types for the SIMT scalar sequencer: opcodes, default
// geometry and the decoded loop-control class of a fetched instruction.
package simt_seq_ctrl_pkg;

    localparam int DEF_LANES      = 16;
    localparam int DEF_PC_W       = 16;
    localparam int DEF_CNT_W      = 16;
    localparam int DEF_LOOP_DEPTH = 4;

    localparam logic [3:0] OP_CMOV = 4'd8;
    localparam logic [3:0] OP_BLTZ = 4'd13;
    localparam logic [3:0] OP_SETX = 4'd14;
    localparam logic [3:0] OP_LOOP = 4'd15;

    typedef logic [DEF_LANES-1:0] lane_mask_t;

    typedef enum logic [1:0] {
        LC_NONE = 2'd0,
        LC_SETX = 2'd1,
        LC_LOOP = 2'd2
    } loop_ctl_e;

endpackage

// File: rtl/simt_seq_ctrl_min_reduce.sv
// Combinational min tree over N registered W-bit values; unused leaves of the
// power-of-two tree are padded with all-ones so they never win.
module simt_seq_ctrl_min_reduce #(
    parameter int N = 16,
    parameter int W = 16
) (
    input  logic [N*W-1:0] i_vals,
    output logic [W-1:0]   o_min
);

    localparam int P = 1 << $clog2(N);

    logic [W-1:0] w_node [2*P-1];

    // Leaves at P-1..2P-2, each parent takes the smaller of its two children.
    always_comb begin
        for (int i = 0; i < 2*P-1; i++) begin
            w_node[i] = {W{1'b1}};
        end
        for (int i = 0; i < P; i++) begin
            if (i < N) begin
                w_node[P-1+i] = i_vals[i*W +: W];
            end else begin
                w_node[P-1+i] = {W{1'b1}};
            end
        end
        for (int i = P-2; i >= 0; i--) begin
            if (w_node[2*i+1] < w_node[2*i+2]) begin
                w_node[i] = w_node[2*i+1];
            end else begin
                w_node[i] = w_node[2*i+2];
            end
        end
    end

    assign o_min = w_node[0];

endmodule

// File: rtl/simt_seq_ctrl.sv
// SIMT scalar sequencer: fetch PC, per-lane forward-branch PCs with
// reconvergence skip, and a nested SETX/LOOP hardware-loop stack.
module simt_seq_ctrl
    import simt_seq_ctrl_pkg::*;
#(
    parameter int LANES      = DEF_LANES,
    parameter int PC_W       = DEF_PC_W,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int LOOP_DEPTH = DEF_LOOP_DEPTH
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             stall,
    output logic [PC_W-1:0]  pc,
    input  logic             f_is_loop,
    input  logic             f_is_setx,
    input  logic [PC_W-1:0]  f_imm,
    output logic             issue_valid,
    input  logic             br_valid,
    input  logic [PC_W-1:0]  br_pc,
    input  logic [PC_W-1:0]  br_target,
    input  logic [LANES-1:0] br_taken,
    input  logic [PC_W-1:0]  x_pc,
    output logic [LANES-1:0] x_mask,
    output logic             err_ovf,
    output logic             err_unf
);

    localparam int SP_W  = $clog2(LOOP_DEPTH + 1);
    localparam int IDX_W = (LOOP_DEPTH > 1) ? $clog2(LOOP_DEPTH) : 1;

    logic [PC_W-1:0]    r_pc;
    logic [PC_W-1:0]    r_nep [LANES];
    logic [CNT_W-1:0]   r_stk [LOOP_DEPTH];
    logic [SP_W-1:0]    r_sp;
    logic               r_err_ovf;
    logic               r_err_unf;

    logic [LANES*PC_W-1:0] w_nep_flat;
    logic [PC_W-1:0]       w_nep_min;
    logic [PC_W-1:0]       w_pc_inc;
    logic [PC_W-1:0]       w_pc_adv;
    logic [IDX_W-1:0]      w_top_idx;
    logic [IDX_W-1:0]      w_push_idx;
    logic [CNT_W-1:0]      w_top;
    logic                  w_sp_empty;
    logic                  w_sp_full;
    loop_ctl_e             w_ctl;

    // Flatten per-lane branch PCs for the reduction and build the lane mask.
    always_comb begin
        w_nep_flat = {(LANES*PC_W){1'b0}};
        x_mask     = {LANES{1'b0}};
        for (int l = 0; l < LANES; l++) begin
            w_nep_flat[l*PC_W +: PC_W] = r_nep[l];
            x_mask[l]                  = (x_pc >= r_nep[l]);
        end
    end

    simt_seq_ctrl_min_reduce #(.N(LANES), .W(PC_W)) u_min (
        .i_vals (w_nep_flat),
        .o_min  (w_nep_min)
    );

    // Sequential-advance target and loop-control decode; LOOP beats SETX.
    always_comb begin
        w_pc_inc   = r_pc + PC_W'(1);
        w_pc_adv   = (w_pc_inc < w_nep_min) ? w_nep_min : w_pc_inc;
        w_sp_empty = (r_sp == {SP_W{1'b0}});
        w_sp_full  = (r_sp == SP_W'(LOOP_DEPTH));
        w_top_idx  = IDX_W'(r_sp - SP_W'(1));
        w_push_idx = IDX_W'(r_sp);
        w_top      = r_stk[w_top_idx];
        if (f_is_loop) begin
            w_ctl = LC_LOOP;
        end else if (f_is_setx) begin
            w_ctl = LC_SETX;
        end else begin
            w_ctl = LC_NONE;
        end
    end

    // PC, loop stack, error flags and per-lane branch PCs; branches land even under stall.
    always_ff @(negedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pc      <= {PC_W{1'b0}};
            r_sp      <= {SP_W{1'b0}};
            r_err_ovf <= 1'b0;
            r_err_unf <= 1'b0;
            for (int l = 0; l < LANES; l++) begin
                r_nep[l] <= {PC_W{1'b0}};
            end
            for (int d = 0; d < LOOP_DEPTH; d++) begin
                r_stk[d] <= {CNT_W{1'b0}};
            end
        end else begin
            for (int l = 0; l < LANES; l++) begin
                if (br_valid && br_taken[l] && (br_pc >= r_nep[l])) begin
                    r_nep[l] <= br_target;
                end
            end
            if (!stall) begin
                case (w_ctl)
                    LC_LOOP: begin
                        if (w_sp_empty) begin
                            r_err_unf <= 1'b1;
                            r_pc      <= w_pc_adv;
                        end else if (w_top != {CNT_W{1'b0}}) begin
                            r_pc             <= f_imm;
                            r_stk[w_top_idx] <= w_top - CNT_W'(1);
                        end else begin
                            r_sp <= r_sp - SP_W'(1);
                            r_pc <= w_pc_adv;
                        end
                    end
                    LC_SETX: begin
                        if (w_sp_full) begin
                            r_err_ovf <= 1'b1;
                        end else begin
                            r_stk[w_push_idx] <= f_imm[CNT_W-1:0];
                            r_sp              <= r_sp + SP_W'(1);
                        end
                        r_pc <= w_pc_adv;
                    end
                    default: begin
                        r_pc <= w_pc_adv;
                    end
                endcase
            end
        end
    end

    assign pc          = r_pc;
    assign err_ovf     = r_err_ovf;
    assign err_unf     = r_err_unf;
    assign issue_valid = !stall && !f_is_loop && !f_is_setx;

endmodule

// File: tb/tb_simt_seq_ctrl.sv
// Directed bench for simt_seq_ctrl: state changes on the falling clock edge,
// so stimulus is applied and outputs are checked just after the rising edge.
module tb_simt_seq_ctrl;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        stall = 1'b0;
    logic [15:0] pc;
    logic        f_is_loop = 1'b0;
    logic        f_is_setx = 1'b0;
    logic [15:0] f_imm = 16'h0000;
    logic        issue_valid;
    logic        br_valid = 1'b0;
    logic [15:0] br_pc = 16'h0000;
    logic [15:0] br_target = 16'h0000;
    logic [15:0] br_taken = 16'h0000;
    logic [15:0] x_pc = 16'h0000;
    logic [15:0] x_mask;
    logic        err_ovf;
    logic        err_unf;

    int total = 0;
    int bad = 0;

    simt_seq_ctrl dut (
        .clock(clock), .reset_n(reset_n), .stall(stall), .pc(pc),
        .f_is_loop(f_is_loop), .f_is_setx(f_is_setx), .f_imm(f_imm),
        .issue_valid(issue_valid), .br_valid(br_valid), .br_pc(br_pc),
        .br_target(br_target), .br_taken(br_taken), .x_pc(x_pc),
        .x_mask(x_mask), .err_ovf(err_ovf), .err_unf(err_unf)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(negedge clock);
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        stall = 1'b0; f_is_loop = 1'b0; f_is_setx = 1'b0; f_imm = 16'h0000;
        br_valid = 1'b0; br_pc = 16'h0000; br_target = 16'h0000;
        br_taken = 16'h0000; x_pc = 16'h0000;
    endtask

    task automatic do_reset();
        @(posedge clock);
        #1;
        reset_n = 1'b0;
        clear_inputs();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (pc !== 16'h0000) begin bad++; $display("FAIL reset_pc got=%h want=0000", pc); end
        total++; if (x_mask !== 16'hFFFF) begin bad++; $display("FAIL reset_mask got=%h want=ffff", x_mask); end
        total++; if ({err_ovf, err_unf} !== 2'b00) begin bad++; $display("FAIL reset_err got=%b want=00", {err_ovf, err_unf}); end
        total++; if (issue_valid !== 1'b1) begin bad++; $display("FAIL reset_issue got=%b want=1", issue_valid); end
    endtask

    task automatic test_nested_loops();
        logic [15:0] exp_pc [20];
        logic [15:0] cur;
        logic        exp_iv;
        exp_pc = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd2, 16'd3, 16'd4, 16'd1, 16'd2, 16'd3,
                   16'd2, 16'd3, 16'd4, 16'd1, 16'd2, 16'd3, 16'd2, 16'd3, 16'd4, 16'd5};
        do_reset();
        for (int i = 0; i < 20; i++) begin
            total++;
            if (pc !== exp_pc[i]) begin bad++; $display("FAIL nest_pc[%0d] got=%h want=%h", i, pc, exp_pc[i]); end
            cur = exp_pc[i];
            f_is_loop = 1'b0; f_is_setx = 1'b0; f_imm = 16'h0000;
            case (cur)
                16'd0:   begin f_is_setx = 1'b1; f_imm = 16'd2; end
                16'd1:   begin f_is_setx = 1'b1; f_imm = 16'd1; end
                16'd3:   begin f_is_loop = 1'b1; f_imm = 16'd2; end
                16'd4:   begin f_is_loop = 1'b1; f_imm = 16'd1; end
                default: begin f_imm = 16'h0000; end
            endcase
            exp_iv = !(cur == 16'd0 || cur == 16'd1 || cur == 16'd3 || cur == 16'd4);
            #1;
            total++;
            if (issue_valid !== exp_iv) begin bad++; $display("FAIL nest_issue[%0d] got=%b want=%b", i, issue_valid, exp_iv); end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_divergence();
        do_reset();
        x_pc = 16'h0007;
        #1;
        total++; if (x_mask !== 16'hFFFF) begin bad++; $display("FAIL div_pre_mask got=%h want=ffff", x_mask); end
        br_valid = 1'b1; br_pc = 16'h0005; br_target = 16'h0010; br_taken = 16'h00FF;
        tick();
        br_valid = 1'b0;
        #1;
        total++; if (x_mask !== 16'hFF00) begin bad++; $display("FAIL div_mask7 got=%h want=ff00", x_mask); end
        x_pc = 16'h0010;
        #1;
        total++; if (x_mask !== 16'hFFFF) begin bad++; $display("FAIL div_mask10 got=%h want=ffff", x_mask); end
        total++; if (pc !== 16'h0001) begin bad++; $display("FAIL div_pc1 got=%h want=0001", pc); end
        tick();
        total++; if (pc !== 16'h0002) begin bad++; $display("FAIL div_pc2 got=%h want=0002", pc); end
    endtask

    task automatic test_reconvergence();
        do_reset();
        for (int i = 0; i < 7; i++) tick();
        total++; if (pc !== 16'h0007) begin bad++; $display("FAIL rc_pc7 got=%h want=0007", pc); end
        br_valid = 1'b1; br_pc = 16'h0007; br_target = 16'h0040; br_taken = 16'hFFFF;
        tick();
        br_valid = 1'b0;
        total++; if (pc !== 16'h0008) begin bad++; $display("FAIL rc_pc8 got=%h want=0008", pc); end
        tick();
        total++; if (pc !== 16'h0040) begin bad++; $display("FAIL rc_skip got=%h want=0040", pc); end
        x_pc = 16'h003F;
        #1;
        total++; if (x_mask !== 16'h0000) begin bad++; $display("FAIL rc_mask3f got=%h want=0000", x_mask); end
        br_valid = 1'b1; br_pc = 16'h0020; br_target = 16'h0050; br_taken = 16'h0001;
        tick();
        br_valid = 1'b0; x_pc = 16'h0045;
        #1;
        total++; if (x_mask !== 16'hFFFF) begin bad++; $display("FAIL rc_ignored got=%h want=ffff", x_mask); end
        br_valid = 1'b1; br_pc = 16'h0041; br_target = 16'h0060; br_taken = 16'h0002;
        tick();
        br_valid = 1'b0;
        #1;
        total++; if (x_mask !== 16'hFFFD) begin bad++; $display("FAIL rc_applied got=%h want=fffd", x_mask); end
        total++; if (pc !== 16'h0042) begin bad++; $display("FAIL rc_pc42 got=%h want=0042", pc); end
    endtask

    task automatic test_stack_errors();
        do_reset();
        f_is_setx = 1'b1; f_imm = 16'h0000;
        for (int i = 0; i < 4; i++) tick();
        total++; if (err_ovf !== 1'b0) begin bad++; $display("FAIL ovf_early got=%b want=0", err_ovf); end
        tick();
        total++; if (err_ovf !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b want=1", err_ovf); end
        total++; if (pc !== 16'h0005) begin bad++; $display("FAIL ovf_pc got=%h want=0005", pc); end
        f_is_setx = 1'b0; f_is_loop = 1'b1; f_imm = 16'h0000;
        for (int i = 0; i < 4; i++) tick();
        total++; if (err_unf !== 1'b0) begin bad++; $display("FAIL unf_early got=%b want=0", err_unf); end
        tick();
        f_is_loop = 1'b0;
        total++; if (err_unf !== 1'b1) begin bad++; $display("FAIL unf_set got=%b want=1", err_unf); end
        total++; if (pc !== 16'h000A) begin bad++; $display("FAIL unf_pc got=%h want=000a", pc); end
        total++; if (err_ovf !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b want=1", err_ovf); end
    endtask

    task automatic test_stall();
        do_reset();
        for (int i = 0; i < 3; i++) tick();
        stall = 1'b1; f_is_loop = 1'b1;
        br_valid = 1'b1; br_pc = 16'h0002; br_target = 16'h0008; br_taken = 16'h000F;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL stall_issue[%0d] got=%b want=0", i, issue_valid); end
            tick();
            br_valid = 1'b0;
            total++; if (pc !== 16'h0003) begin bad++; $display("FAIL stall_pc[%0d] got=%h want=0003", i, pc); end
        end
        total++; if (err_unf !== 1'b0) begin bad++; $display("FAIL stall_err got=%b want=0", err_unf); end
        x_pc = 16'h0005;
        #1;
        total++; if (x_mask !== 16'hFFF0) begin bad++; $display("FAIL stall_nep got=%h want=fff0", x_mask); end
        stall = 1'b0; f_is_loop = 1'b0;
        #1;
        total++; if (issue_valid !== 1'b1) begin bad++; $display("FAIL resume_issue got=%b want=1", issue_valid); end
        tick();
        total++; if (pc !== 16'h0004) begin bad++; $display("FAIL resume_pc got=%h want=0004", pc); end
    endtask

    task automatic test_reset_midrun();
        do_reset();
        f_is_loop = 1'b1;
        tick();
        f_is_loop = 1'b0;
        total++; if (err_unf !== 1'b1) begin bad++; $display("FAIL mid_unf got=%b want=1", err_unf); end
        for (int i = 0; i < 30; i++) tick();
        br_valid = 1'b1; br_pc = 16'h001F; br_target = 16'h0030; br_taken = 16'h0008;
        tick();
        br_valid = 1'b0; x_pc = 16'h0020;
        #1;
        total++; if (pc !== 16'h0020) begin bad++; $display("FAIL mid_pc got=%h want=0020", pc); end
        total++; if (x_mask !== 16'hFFF7) begin bad++; $display("FAIL mid_mask got=%h want=fff7", x_mask); end
        reset_n = 1'b0;
        #1;
        total++; if (pc !== 16'h0000) begin bad++; $display("FAIL mid_rst_pc got=%h want=0000", pc); end
        total++; if (x_mask !== 16'hFFFF) begin bad++; $display("FAIL mid_rst_mask got=%h want=ffff", x_mask); end
        total++; if ({err_ovf, err_unf} !== 2'b00) begin bad++; $display("FAIL mid_rst_err got=%b want=00", {err_ovf, err_unf}); end
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_nested_loops();
        test_divergence();
        test_reconvergence();
        test_stack_errors();
        test_stall();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
